// File: rtl/rbus_pkg.sv
// Shared rbus definitions: word layout, header field positions, the
// packet descriptor and the state encodings used by the egress buffer.
package rbus_pkg;

  localparam int RBUS_DW      = 72;
  localparam int HDR_LANE_BIT = 71;
  localparam int HDR_LEN_LSB  = 64;
  localparam int HDR_LEN_W    = 3;

  typedef logic [RBUS_DW-1:0] rbus_word_t;

  typedef struct packed {
    logic                 lane;
    logic [HDR_LEN_W-1:0] len;
  } pkt_desc_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_DROP = 2'd2
  } in_state_t;

  typedef enum logic {
    S_OIDLE = 1'b0,
    S_RD    = 1'b1
  } out_state_t;

  // Pull the lane and payload length out of a header word.
  function automatic pkt_desc_t hdr_desc(input rbus_word_t w);
    pkt_desc_t d;
    d.lane = w[HDR_LANE_BIT];
    d.len  = w[HDR_LEN_LSB +: HDR_LEN_W];
    return d;
  endfunction

endpackage

// File: rtl/rbus_egress_ram.sv
// Simple dual-port packet storage, one write and one read port, registered
// read with one cycle of latency. No reset on the array or read register so
// it maps onto block RAM.
module rbus_egress_ram
  import rbus_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  rbus_word_t    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output rbus_word_t    rd_data
);

  rbus_word_t mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port; holds its value when not reading.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/rbus_egress_pktbuf.sv
// Egress packet buffer behind an rbus mux output. Packets are absorbed into a
// ring buffer and re-issued whole. Lane 1 gets RESERVE words of headroom.
// Build option: define RBUS_EGRESS_CUT_THROUGH_EN to push the descriptor at
// the header instead of after the last word (cut-through).
//
// Input FSM
//   state  | meaning
//   S_IDLE | waiting for a header
//   S_WR   | writing payload words, cnt_q = words still to come
//   S_DROP | discarding a packet that did not fit, cnt_q = words still to come
// Output FSM
//   state   | meaning
//   S_OIDLE | nothing being read
//   S_RD    | reading a packet, rd_cnt_q = payload words still to read
module rbus_egress_pktbuf
  import rbus_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int PKT_MAX = 8,
  parameter int RESERVE = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_stb,
  input  logic               i_sof,
  input  logic [RBUS_DW-1:0] i_data,
  output logic [1:0]         i_rdy,
  output logic [1:0]         i_rdyE,
  output logic               o_stb,
  output logic               o_sof,
  output logic [RBUS_DW-1:0] o_data,
  input  logic [1:0]         o_rdy,
  input  logic [1:0]         o_rdyE,
  output logic               ff_err
);

  localparam int AW         = $clog2(DEPTH);
  localparam int FW         = AW + 1;
  localparam int DESC_DEPTH = DEPTH / 2;
  localparam int DAW        = $clog2(DESC_DEPTH);
  localparam int DCW        = DAW + 1;

`ifdef RBUS_EGRESS_CUT_THROUGH_EN
  localparam bit CUT_THROUGH = 1'b1;
`else
  localparam bit CUT_THROUGH = 1'b0;
`endif

  localparam logic [FW-1:0] TH_RDY1  = FW'(PKT_MAX);
  localparam logic [FW-1:0] TH_RDY0  = FW'(PKT_MAX + RESERVE);
  localparam logic [FW-1:0] TH_RDYE1 = FW'(2 * PKT_MAX);
  localparam logic [FW-1:0] TH_RDYE0 = FW'(2 * PKT_MAX + RESERVE);
  // One packet may be mid-flight plus a same-cycle abort commit, so keep two
  // descriptor slots spare when accepting a header.
  localparam logic [DCW-1:0] DESC_ACCEPT_MAX = DCW'(DESC_DEPTH - 3);

  // input side
  in_state_t            ist_q, ist_d;
  logic [HDR_LEN_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  pkt_desc_t            cur_desc_q, cur_desc_d;
  logic [FW-1:0]        free_q, free_d;
  logic                 err_q, err_d;
  logic [1:0]           i_rdy_q, i_rdy_d, i_rdye_q, i_rdye_d;

  pkt_desc_t            new_desc;
  logic [FW-1:0]        hdr_need;
  logic                 hdr_fit;
  logic                 take_hdr, err_set, push_old, push_new, wr_en;
  logic [AW-1:0]        skip, hdr_base, wr_addr;
  logic [FW-1:0]        reserve;

  // output side
  out_state_t           ost_q, ost_d;
  logic [HDR_LEN_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic                 o_stb_q, o_stb_d, o_sof_q, o_sof_d;
  logic                 issue, pop;
  pkt_desc_t            head;
  rbus_word_t           ram_rd;

  // descriptor queue
  pkt_desc_t            desc_mem [DESC_DEPTH];
  logic [DAW-1:0]       dwp_q, dwp_d, drp_q, drp_d, dwp_inc;
  logic [DCW-1:0]       dcnt_q, dcnt_d;
  logic                 push_a, push_b;
  pkt_desc_t            desc_a;

  // Early-ready from downstream is status only; arbitration ignores it.
  logic unused_o_rdye;
  assign unused_o_rdye = ^o_rdyE;

  assign new_desc = hdr_desc(i_data);
  assign hdr_need = FW'(new_desc.len) + FW'(1);
  assign hdr_fit  = (free_q >= hdr_need) && (dcnt_q <= DESC_ACCEPT_MAX);
  assign head     = desc_mem[drp_q];

  // Input FSM next state, buffer writes, reservations and descriptor pushes.
  always_comb begin
    ist_d      = ist_q;
    cnt_d      = cnt_q;
    wr_ptr_d   = wr_ptr_q;
    cur_desc_d = cur_desc_q;
    take_hdr   = 1'b0;
    err_set    = 1'b0;
    push_old   = 1'b0;
    push_new   = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = wr_ptr_q;
    skip       = '0;
    reserve    = '0;
    case (ist_q)
      S_IDLE: begin
        if (i_stb) begin
          if (i_sof) take_hdr = 1'b1;
          else       err_set  = 1'b1;
        end
      end
      S_WR: begin
        if (i_stb && i_sof) begin
          // Abandon the partial packet: its unwritten tail stays reserved and
          // is skipped, so its descriptor length still matches the ring.
          err_set  = 1'b1;
          skip     = AW'(cnt_q);
          push_old = !CUT_THROUGH;
          take_hdr = 1'b1;
        end else if (i_stb) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          cnt_d    = cnt_q - HDR_LEN_W'(1);
          if (cnt_q == HDR_LEN_W'(1)) begin
            push_old = !CUT_THROUGH;
            ist_d    = S_IDLE;
          end
        end else begin
          err_set = 1'b1;
        end
      end
      S_DROP: begin
        if (i_stb && i_sof) begin
          err_set  = 1'b1;
          take_hdr = 1'b1;
        end else if (i_stb) begin
          cnt_d = cnt_q - HDR_LEN_W'(1);
          if (cnt_q == HDR_LEN_W'(1)) ist_d = S_IDLE;
        end
      end
      default: ist_d = S_IDLE;
    endcase

    hdr_base = wr_ptr_q + skip;
    if (take_hdr) begin
      cnt_d = new_desc.len;
      if (hdr_fit) begin
        wr_en      = 1'b1;
        wr_addr    = hdr_base;
        wr_ptr_d   = hdr_base + AW'(1);
        reserve    = hdr_need;
        cur_desc_d = new_desc;
        push_new   = CUT_THROUGH || (new_desc.len == '0);
        ist_d      = (new_desc.len == '0) ? S_IDLE : S_WR;
      end else begin
        err_set  = 1'b1;
        wr_ptr_d = hdr_base;
        ist_d    = (new_desc.len == '0) ? S_IDLE : S_DROP;
      end
    end
  end

  // Output FSM: start on the head descriptor when its lane is ready, then
  // stream without stalling; a new packet may start right after the last word.
  always_comb begin
    ost_d    = ost_q;
    rd_cnt_d = rd_cnt_q;
    rd_ptr_d = rd_ptr_q;
    issue    = 1'b0;
    pop      = 1'b0;
    o_sof_d  = 1'b0;
    if ((ost_q == S_RD) && (rd_cnt_q != '0)) begin
      issue    = 1'b1;
      rd_cnt_d = rd_cnt_q - HDR_LEN_W'(1);
    end else if ((dcnt_q != '0) && o_rdy[head.lane]) begin
      issue    = 1'b1;
      pop      = 1'b1;
      o_sof_d  = 1'b1;
      rd_cnt_d = head.len;
      ost_d    = S_RD;
    end else begin
      ost_d = S_OIDLE;
    end
    if (issue) rd_ptr_d = rd_ptr_q + AW'(1);
    o_stb_d = issue;
  end

  // Space accounting, ready flags and descriptor queue bookkeeping.
  always_comb begin
    free_d   = free_q - reserve + FW'(issue);
    i_rdy_d  = {free_d >= TH_RDY1, free_d >= TH_RDY0};
    i_rdye_d = {free_d >= TH_RDYE1, free_d >= TH_RDYE0};
    err_d    = err_q | err_set;
    push_a   = push_old | push_new;
    push_b   = push_old & push_new;
    desc_a   = push_old ? cur_desc_q : new_desc;
    dwp_inc  = dwp_q + DAW'(1);
    dwp_d    = dwp_q + DAW'(push_a) + DAW'(push_b);
    drp_d    = drp_q + DAW'(pop);
    dcnt_d   = dcnt_q + DCW'(push_a) + DCW'(push_b) - DCW'(pop);
  end

  // Input-side state and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ist_q      <= S_IDLE;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      cur_desc_q <= '0;
      free_q     <= FW'(DEPTH);
      err_q      <= 1'b0;
      i_rdy_q    <= '0;
      i_rdye_q   <= '0;
    end else begin
      ist_q      <= ist_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      cur_desc_q <= cur_desc_d;
      free_q     <= free_d;
      err_q      <= err_d;
      i_rdy_q    <= i_rdy_d;
      i_rdye_q   <= i_rdye_d;
    end
  end

  // Output-side state and registered strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ost_q    <= S_OIDLE;
      rd_cnt_q <= '0;
      rd_ptr_q <= '0;
      o_stb_q  <= 1'b0;
      o_sof_q  <= 1'b0;
    end else begin
      ost_q    <= ost_d;
      rd_cnt_q <= rd_cnt_d;
      rd_ptr_q <= rd_ptr_d;
      o_stb_q  <= o_stb_d;
      o_sof_q  <= o_sof_d;
    end
  end

  // Descriptor queue pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwp_q  <= '0;
      drp_q  <= '0;
      dcnt_q <= '0;
    end else begin
      dwp_q  <= dwp_d;
      drp_q  <= drp_d;
      dcnt_q <= dcnt_d;
    end
  end

  // Descriptor storage; an aborted packet and a new zero-length packet can
  // commit in the same cycle, hence two write slots.
  always_ff @(posedge clk) begin
    if (push_a) desc_mem[dwp_q]   <= desc_a;
    if (push_b) desc_mem[dwp_inc] <= new_desc;
  end

  rbus_egress_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (i_data),
    .rd_en   (issue),
    .rd_addr (rd_ptr_q),
    .rd_data (ram_rd)
  );

  assign o_stb  = o_stb_q;
  assign o_sof  = o_sof_q;
  assign o_data = o_stb_q ? ram_rd : '0;
  assign i_rdy  = i_rdy_q;
  assign i_rdyE = i_rdye_q;
  assign ff_err = err_q;

endmodule
